// File: rtl/qdiv_seq.sv
// qdiv_seq: iterative sign-magnitude Q-format divider (restoring shift-subtract).
// One quotient bit is produced per clock. A start is taken only while idle,
// and the result and flags are held until the next accepted start.
module qdiv_seq #(
    parameter int Q = 15,   // fractional bits; assumed >= 1
    parameter int N = 32    // total width including sign; N > Q+1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_overflow,
    output logic         o_div_zero
);

    // Working dividend / quotient width: magnitude bits plus Q appended zeros.
    localparam int W  = N - 1 + Q;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic            sign_q;
    logic [N-1:0]    rem_q;       // N bits so the shifted remainder never truncates
    logic [W-1:0]    work_q;      // dividend bits shift out of the top, quotient bits in at the bottom
    logic [N-2:0]    dvs_q;       // divisor magnitude
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    quotient_q;
    logic            busy_q;
    logic            done_q;
    logic            ovf_q;
    logic            dz_q;

    logic [N-1:0]    rem_shift;
    logic [N:0]      trial;
    logic [N-1:0]    rem_d;
    logic [W-1:0]    work_d;
    logic            ovf_d;
    logic [N-2:0]    mag_d;

    // One restoring step plus the saturation/result formatting used on entry to DONE.
    always_comb begin
        rem_shift = {rem_q[N-2:0], work_q[W-1]};
        // Extra top bit acts as the borrow of the trial subtraction.
        trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
        if (trial[N]) begin
            rem_d  = rem_shift;
            work_d = {work_q[W-2:0], 1'b0};
        end else begin
            rem_d  = trial[N-1:0];
            work_d = {work_q[W-2:0], 1'b1};
        end
        ovf_d = |work_q[W-1:N-1];
        mag_d = (dz_q || ovf_d) ? '1 : work_q[N-2:0];
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            rem_q      <= '0;
            work_q     <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // done_q high means this is the completion cycle, where a
                    // start is still treated as arriving during DONE.
                    if (i_start && !done_q) begin
                        sign_q <= i_dividend[N-1] ^ i_divisor[N-1];
                        rem_q  <= '0;
                        work_q <= {i_dividend[N-2:0], {Q{1'b0}}};
                        dvs_q  <= i_divisor[N-2:0];
                        cnt_q  <= CW'(W);
                        busy_q <= 1'b1;
                        ovf_q  <= 1'b0;
                        if (i_divisor[N-2:0] == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= DONE;
                end
                DONE: begin
                    // Zero magnitude always gets a positive sign.
                    quotient_q <= {sign_q & (|mag_d), mag_d};
                    ovf_q      <= ovf_d & ~dz_q;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_quotient = quotient_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = ovf_q;
    assign o_div_zero = dz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: directed plus randomized checks of qdiv_seq against an
// arithmetic reference model of sign-magnitude Q-format division.
module tb_qdiv_seq;

    localparam int N = 32;
    localparam int Q = 15;
    localparam int W = N - 1 + Q;
    localparam longint unsigned MAXMAG = (64'd1 << (N - 1)) - 64'd1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic [N-1:0] i_dividend = '0;
    logic [N-1:0] i_divisor = '0;
    logic [N-1:0] o_quotient;
    logic         o_busy;
    logic         o_done;
    logic         o_overflow;
    logic         o_div_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0] q;
        logic         ovf;
        logic         dz;
    } exp_t;

    qdiv_seq #(.Q(Q), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_quotient (o_quotient),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overflow (o_overflow),
        .o_div_zero (o_div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: magnitude = floor(|a| * 2^Q / |b|), saturating, sign = XOR.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t            r;
        longint unsigned ma, mb, mag;
        logic            s;
        ma    = longint'(a[N-2:0]);
        mb    = longint'(b[N-2:0]);
        s     = a[N-1] ^ b[N-1];
        r.dz  = (mb == 0);
        r.ovf = 1'b0;
        if (r.dz) begin
            mag = MAXMAG;
        end else begin
            mag = (ma << Q) / mb;
            if (mag > MAXMAG) begin
                mag   = MAXMAG;
                r.ovf = 1'b1;
            end
        end
        r.q = {s & (mag != 0), mag[N-2:0]};
        return r;
    endfunction

    // Run one division; optionally pulse i_start with other operands mid-CALC.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit mid_start);
        exp_t         e;
        int           cycles;
        int           exp_lat;
        logic [N-1:0] held;
        e       = model(a, b);
        exp_lat = e.dz ? 1 : W + 1;
        @(negedge clk);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        check("busy_after_accept", 64'(o_busy), 64'(!e.dz || 1'b1));
        check("dz_at_accept", 64'(o_div_zero), 64'(e.dz));
        cycles = 0;
        while (!o_done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mid_start && cycles == 10) begin
                i_start    = 1'b1;
                i_dividend = $urandom;
                i_divisor  = $urandom;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check("done_seen", 64'(o_done), 64'd1);
        check("latency", 64'(cycles), 64'(exp_lat));
        check("quotient", 64'(o_quotient), 64'(e.q));
        check("overflow", 64'(o_overflow), 64'(e.ovf));
        check("div_zero", 64'(o_div_zero), 64'(e.dz));
        check("busy_at_done", 64'(o_busy), 64'd0);
        // A start in the o_done cycle must be ignored.
        held       = o_quotient;
        i_start    = 1'b1;
        i_dividend = $urandom;
        i_divisor  = 32'h0001_0000;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("done_pulse_one", 64'(o_done), 64'd0);
        check("start_in_done_ignored", 64'(o_busy), 64'd0);
        check("result_held", 64'(o_quotient), 64'(held));
    endtask

    task automatic run_abort();
        int done_cnt;
        @(negedge clk);
        i_start    = 1'b1;
        i_dividend = 32'h0000_8000;
        i_divisor  = 32'h0001_0000;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_quotient", 64'(o_quotient), 64'd0);
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_flags", 64'({o_done, o_overflow, o_div_zero}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (o_done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
    endtask

    initial begin
        logic [N-1:0] a, b;
        #1;
        check("reset_quotient", 64'(o_quotient), 64'd0);
        check("reset_flags", 64'({o_busy, o_done, o_overflow, o_div_zero}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div(32'h0000_8000, 32'h0001_0000, 1'b0);   // 1.0 / 2.0
        run_div(32'h8001_8000, 32'h0001_0000, 1'b0);   // -3.0 / 2.0
        run_div(32'h8001_8000, 32'h8001_0000, 1'b0);   // -3.0 / -2.0
        run_div(32'h0000_0000, 32'h8002_8000, 1'b0);   // 0 / -5.0
        run_div(32'h0000_0001, 32'h0001_0000, 1'b0);   // truncates to 0
        run_div(32'h8000_8000, 32'h0000_0000, 1'b0);   // divide by zero
        run_div(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);   // overflow
        run_div(32'h0000_8000, 32'h0001_0000, 1'b0);   // clears flags
        run_div(32'h8000_0001, 32'h0000_0003, 1'b0);   // tiny negative result
        run_div(32'h0003_0000, 32'h0000_4000, 1'b1);   // mid-CALC start ignored
        run_abort();
        run_div(32'h0000_8000, 32'h0001_0000, 1'b0);   // normal after abort

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 4)
                0: b[N-2:0] = b[N-2:0] >> $urandom_range(0, N - 2);
                1: a[N-2:0] = a[N-2:0] >> $urandom_range(0, N - 2);
                2: b[N-2:0] = (i == 2) ? '0 : b[N-2:0] >> 16;
                default: ;
            endcase
            run_div(a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so a stuck design still reaches an end.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
